i2c_controller: RTL and testbench

- Single-master I2C bus controller: the stage directly upstream of i2c_peripheral, driving the SCL/SDA lines it responds to.
- Accepts one-byte read or write commands over a valid/ready interface and generates the bus sequence START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Returns a one-cycle response carrying read data and NACK status.
- Open-drain lines are modelled as drive-low enables plus sampled inputs; the top level builds the tristate pads.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_scl_timer.sv | 64 ++++++
 rtl/i2c_controller.sv | 151 +++++++++++++++
 tb/tb_i2c_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C controller.
// Build option: I2C_CTRL_CLK_STRETCH_EN enables SCL clock stretching.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WR_ACK,
    ST_READ,
    ST_RD_ACK,
    ST_STOP,
    ST_DONE
  } i2c_ctrl_state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } i2c_phase_e;

endpackage

// File: rtl/i2c_scl_timer.sv
// SCL quarter-period timer: CLK_DIV clocks per quarter, phase Q0..Q3.
// Ports: clk_i, rst_i, run_i (count enable), scl_i (sampled SCL),
//        adv_o (last clock of a quarter), phase_o (current quarter).
// Build option: I2C_CTRL_CLK_STRETCH_EN holds the timer in Q2 while
// a peripheral keeps SCL low.
module i2c_scl_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       scl_i,
  output logic       adv_o,
  output i2c_phase_e phase_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  i2c_phase_e    phase_q, phase_d;
  logic          hold;

`ifdef I2C_CTRL_CLK_STRETCH_EN
  // Released SCL still low: the peripheral is stretching.
  assign hold = (phase_q == Q2) && (cnt_q == '0) && !scl_i;
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold = 1'b0;
`endif

  assign adv_o   = run_i && !hold && (cnt_q == LAST);
  assign phase_o = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (!hold) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = i2c_phase_e'(phase_q + 2'd1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: one-byte read/write per command.
// Ports: cmd_* valid/ready command in, rsp_* one-cycle response out,
//        scl_oe/sda_oe open-drain pull-low enables, scl_i/sda_i lines.
// Build option: I2C_CTRL_CLK_STRETCH_EN (see i2c_scl_timer).
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic [I2C_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [I2C_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_nack,
  output logic                  scl_oe,
  output logic                  sda_oe,
  input  logic                  scl_i,
  input  logic                  sda_i
);

  i2c_ctrl_state_e       state_q;
  logic [I2C_DATA_W-1:0] shift_q, wdata_q, rdata_q;
  logic [2:0]            bit_q;
  logic                  rw_q, ack_q, nack_q;
  logic                  scl_oe_q, sda_oe_q;
  logic                  rdy_q, rv_q, rnack_q;
  logic                  adv, run;
  i2c_phase_e            phase;

  assign run = (state_q != ST_IDLE) && (state_q != ST_DONE);

  i2c_scl_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .run_i   (run),
    .scl_i   (scl_i),
    .adv_o   (adv),
    .phase_o (phase)
  );

  assign cmd_ready = rdy_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = rnack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bit_q    <= '0;
      rw_q     <= I2C_RW_WRITE;
      ack_q    <= 1'b0;
      nack_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rdy_q    <= 1'b1;
      rv_q     <= 1'b0;
      rnack_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cmd_valid) begin
          rdy_q   <= 1'b0;
          rw_q    <= cmd_rw;
          wdata_q <= cmd_wdata;
          shift_q <= {cmd_addr, cmd_rw};
          bit_q   <= '0;
          nack_q  <= 1'b0;
          state_q <= ST_START;
        end
        ST_START: if (adv) begin
          if (phase == Q1) sda_oe_q <= 1'b1;
          if (phase == Q3) begin
            scl_oe_q <= 1'b1;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR, ST_WRITE: if (adv) begin
          unique case (phase)
            Q0: sda_oe_q <= ~shift_q[7];
            Q1: scl_oe_q <= 1'b0;
            Q3: begin
              scl_oe_q <= 1'b1;
              shift_q  <= {shift_q[6:0], 1'b0};
              bit_q    <= bit_q + 3'd1;
              if (bit_q == 3'd7)
                state_q <= (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
            end
            default: ;
          endcase
        end
        ST_ADDR_ACK, ST_WR_ACK, ST_READ, ST_RD_ACK: if (adv) begin
          unique case (phase)
            Q0: sda_oe_q <= 1'b0;
            Q1: scl_oe_q <= 1'b0;
            Q2: begin
              if (state_q == ST_READ) shift_q <= {shift_q[6:0], sda_i};
              else ack_q <= sda_i;
            end
            Q3: begin
              scl_oe_q <= 1'b1;
              unique case (1'b1)
                state_q == ST_ADDR_ACK && !ack_q: begin
                  state_q <= (rw_q == I2C_RW_READ) ? ST_READ : ST_WRITE;
                  shift_q <= wdata_q;
                  bit_q   <= '0;
                end
                state_q == ST_READ: begin
                  bit_q <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= ST_RD_ACK;
                end
                default: begin
                  // Any ACK slot ending here heads to STOP with SDA low.
                  if (state_q != ST_RD_ACK && ack_q) nack_q <= 1'b1;
                  sda_oe_q <= 1'b1;
                  state_q  <= ST_STOP;
                end
              endcase
            end
            default: ;
          endcase
        end
        ST_STOP: if (adv) begin
          if (phase == Q1) scl_oe_q <= 1'b0;
          if (phase == Q2) sda_oe_q <= 1'b0;
          if (phase == Q3) begin
            state_q <= ST_DONE;
            rv_q    <= 1'b1;
            rnack_q <= nack_q;
            if (rw_q == I2C_RW_READ && !nack_q) rdata_q <= shift_q;
          end
        end
        ST_DONE: begin
          rv_q    <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller with a behavioural I2C peripheral
// and a response scoreboard.
module tb_i2c_controller;

  typedef struct {
    logic [7:0] rd;
    logic       nack;
    int         lat;
  } exp_t;

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata, rsp_rdata;
  logic       rsp_valid, rsp_nack;
  logic       scl_oe, sda_oe, scl_line, sda_line;

  int   cyc;
  int   passed, total;
  exp_t exp_q[$];
  int   acc_q[$];

  logic       per_low, stretch_low, stop_seen, acked, rd_ack_oe;
  logic       prev_scl, prev_sda;
  logic [7:0] addr_byte, data_byte, per_sh;
  int         rise_n, st_cnt;
  logic [6:0] per_addr;
  logic [7:0] per_rd;
  logic       wr_ack_en, stretch_en;
  logic [7:0] last_rd;

  assign scl_line = !(scl_oe || stretch_low);
  assign sda_line = !(sda_oe || per_low);

  i2c_controller #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .scl_i     (scl_line),
    .sda_i     (sda_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && cmd_valid && cmd_ready) acc_q.push_back(cyc);

  // Peripheral: decodes bits at SCL rise, drives SDA after SCL fall.
  always @(negedge clk) begin
    logic s, d;
    s = scl_line;
    d = sda_line;
    if (rst) begin
      per_low = 0; stretch_low = 0; stop_seen = 0; acked = 0;
      prev_scl = 1; prev_sda = 1; rise_n = 0; st_cnt = 0;
      addr_byte = 0; data_byte = 0; per_sh = 0; rd_ack_oe = 1'bx;
    end else begin
      if (prev_scl && s && prev_sda && !d) begin
        rise_n = 0; addr_byte = 0; data_byte = 0;
        stop_seen = 0; acked = 0;
      end else if (prev_scl && s && !prev_sda && d) begin
        stop_seen = 1;
      end
      if (!prev_scl && s) begin
        rise_n++;
        if (rise_n <= 8) addr_byte = {addr_byte[6:0], d};
        else if (rise_n >= 10 && rise_n <= 17)
          data_byte = {data_byte[6:0], d};
        if (rise_n == 18) rd_ack_oe = sda_oe;
      end
      if (prev_scl && !s) begin
        per_low = 0;
        if (rise_n == 8 && addr_byte[7:1] == per_addr) begin
          per_low = 1; acked = 1; per_sh = per_rd;
          if (stretch_en) begin stretch_low = 1; st_cnt = 0; end
        end else if (acked && addr_byte[0] && rise_n >= 9 && rise_n <= 16) begin
          per_low = !per_sh[7];
          per_sh = {per_sh[6:0], 1'b0};
        end else if (acked && !addr_byte[0] && rise_n == 17) begin
          per_low = wr_ack_en;
        end
      end
      if (stretch_low && !scl_oe) begin
        st_cnt++;
        if (st_cnt == 21) stretch_low = 0;
      end
      prev_scl = s;
      prev_sda = d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic rw, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] erd,
                      input logic enack, input int elat, input bit keep);
    exp_t e;
    e.rd = erd; e.nack = enack; e.lat = elat;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    if (!keep) begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int rcyc, output int acyc);
    int   n;
    exp_t e;
    n = 0; rcyc = -1; acyc = -1;
    while (n < 3000) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    chk("rsp_seen", rsp_valid, 1);
    if (rsp_valid) begin
      rcyc = cyc;
      e = exp_q.pop_front();
      if (acc_q.size() > 0) acyc = acc_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rd);
      chk("rsp_nack", rsp_nack, e.nack);
      chk("latency", rcyc - acyc, e.lat);
      chk("ready_low_at_rsp", cmd_ready, 0);
      @(negedge clk);
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("ready_after_rsp", cmd_ready, 1);
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int r1, a1, r2, a2, n;
    passed = 0; total = 0;
    rst = 1; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_wdata = 0;
    per_addr = 7'h50; per_rd = 8'h3C; wr_ack_en = 1; stretch_en = 0;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    rst = 0;

    send(1'b0, 7'h50, 8'hA5, last_rd, 1'b0, 321, 0);
    wait_rsp(r1, a1);
    chk("wr_addr_byte", addr_byte, 8'hA0);
    chk("wr_data_byte", data_byte, 8'hA5);
    chk("wr_scl_rises", rise_n, 19);
    chk("wr_stop", stop_seen, 1);

    per_rd = 8'h3C;
    send(1'b1, 7'h50, 8'hFF, 8'h3C, 1'b0, 321, 0);
    wait_rsp(r1, a1);
    last_rd = 8'h3C;
    chk("rd_addr_byte", addr_byte, 8'hA1);
    chk("rd_bus_byte", data_byte, 8'h3C);
    chk("rd_master_nack_released", rd_ack_oe, 0);
    chk("rd_stop", stop_seen, 1);

    send(1'b0, 7'h22, 8'h5A, last_rd, 1'b1, 177, 0);
    wait_rsp(r1, a1);
    chk("anack_addr_byte", addr_byte, 8'h44);
    chk("anack_scl_rises", rise_n, 10);
    chk("anack_stop", stop_seen, 1);

    wr_ack_en = 0;
    send(1'b0, 7'h50, 8'h11, last_rd, 1'b1, 321, 0);
    wait_rsp(r1, a1);
    wr_ack_en = 1;
    chk("dnack_data_byte", data_byte, 8'h11);
    chk("dnack_stop", stop_seen, 1);

    per_rd = 8'hC3;
    @(negedge clk);
    cmd_rw = 1; cmd_addr = 7'h50; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    n = 0;
    while (n < 1000 && !(rise_n >= 12 && scl_oe)) begin
      @(negedge clk);
      n++;
    end
    chk("mid_read_reached", (rise_n >= 12 && scl_oe), 1);
    #2 rst = 1;
    #1;
    chk("mrst_scl_oe", scl_oe, 0);
    chk("mrst_sda_oe", sda_oe, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    acc_q.delete();
    last_rd = 8'h00;
    send(1'b0, 7'h50, 8'h5A, last_rd, 1'b0, 321, 0);
    wait_rsp(r1, a1);
    chk("post_rst_data_byte", data_byte, 8'h5A);

    per_rd = 8'h96;
    send(1'b0, 7'h50, 8'hC7, last_rd, 1'b0, 321, 1);
    @(posedge clk);
    #1;
    cmd_rw = 1; cmd_addr = 7'h50; cmd_wdata = 8'h00;
    begin
      exp_t e;
      e.rd = 8'h96; e.nack = 0; e.lat = 321;
      exp_q.push_back(e);
    end
    wait_rsp(r1, a1);
    @(posedge clk);
    #1 cmd_valid = 0;
    wait_rsp(r2, a2);
    last_rd = 8'h96;
    chk("b2b_accept_cycle", a2 - r1, 1);
    chk("b2b_addr_byte", addr_byte, 8'hA1);
    chk("b2b_rd_byte", data_byte, 8'h96);

`ifdef I2C_CTRL_CLK_STRETCH_EN
    stretch_en = 1;
    send(1'b0, 7'h50, 8'h33, last_rd, 1'b0, 341, 0);
    wait_rsp(r1, a1);
    stretch_en = 0;
    chk("stretch_data_byte", data_byte, 8'h33);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
